multi_counter: RTL
==================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 SHALL have parameter BITS, default 8, counter width per channel (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counters (>=1).
REQ-003 SHALL have parameter STEP_BITS, default 4, width of step input (1..BITS).
REQ-004 SHALL have parameter MODE, default 0, overflow policy: 0 = wrap, 1 = saturate.
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port i_init, input, 1, synchronous clear of all channels.
REQ-008 SHALL have port i_enable, input, CHANNELS, per-channel count enable.
REQ-009 SHALL have port i_inc_dec, input, CHANNELS, per-channel direction: 1 = up, 0 = down.
REQ-010 SHALL have port i_step, input, STEP_BITS, step magnitude shared by all channels.
REQ-011 SHALL have port i_load, input, 1, load strobe.
REQ-012 SHALL have port i_load_chan, input, clog2(CHANNELS) (min 1), target channel of load.
REQ-013 SHALL have port i_load_value, input, BITS, value to load.
REQ-014 SHALL have port i_clear_flags, input, 1, clears sticky flags of all channels.
REQ-015 SHALL have port o_value, output, CHANNELS*BITS, channel n at bits [n*BITS +: BITS].
REQ-016 SHALL have port o_overflow, output, CHANNELS, sticky up-crossing flag per channel.
REQ-017 SHALL have port o_underflow, output, CHANNELS, sticky down-crossing flag per channel.
REQ-018 SHALL have port o_at_max / o_at_min, output, CHANNELS each, combinational value==2^BITS-1 / value==0.

Function
REQ-019 Per channel, per cycle, priority SHALL be: reset > i_init > load (i_load and i_load_chan==n) > count (i_enable[n]) > hold.
REQ-020 Count SHALL add (up) or subtract (down) zero-extended i_step, computed at BITS+1 width; result registered next edge (latency 1).
REQ-021 i_step==0 with enable SHALL leave value unchanged and set no flag.
REQ-022 Up result > 2^BITS-1: MODE 0 SHALL store result mod 2^BITS; MODE 1 SHALL store 2^BITS-1; both SHALL set o_overflow[n].
REQ-023 Down result < 0: MODE 0 SHALL store result mod 2^BITS; MODE 1 SHALL store 0; both SHALL set o_underflow[n].
REQ-024 Saturated channel at limit counting further into it SHALL hold value and set (keep) the flag.
REQ-025 Load SHALL affect only the addressed channel; other enabled channels SHALL count in the same cycle.
REQ-026 i_load_chan >= CHANNELS SHALL cause no load on any channel.
REQ-027 Load and i_init SHALL NOT set or clear flags; flags cleared only by reset or i_clear_flags.
REQ-028 i_clear_flags with a same-cycle new crossing SHALL leave the flag set (set wins).
REQ-029 Channels SHALL be fully independent apart from shared i_step, i_init, load bus, i_clear_flags.

Reset
REQ-030 reset SHALL set every o_value channel to 0 and all o_overflow/o_underflow to 0 on the next rising edge.
REQ-031 reset mid-count SHALL override all other inputs in that cycle; counting resumes the cycle after reset deasserts.
REQ-032 After reset o_at_min SHALL be all ones and o_at_max all zeros.

Structure
REQ-033 MODE encodings (MODE_WRAP=0, MODE_SATURATE=1) SHALL live in shared package multi_counter_pkg.
REQ-034 One sub-module counter_channel (single-channel value, arithmetic, flags) SHALL be instantiated CHANNELS times via generate.
REQ-035 Top level SHALL contain only load decode, flattening, and instantiation.

Verification (BITS=8, CHANNELS=4, STEP_BITS=4)
REQ-036 Reset, then ch0 up step 1 for 3 cycles -> ch0=3, others 0, no flags.
REQ-037 MODE 0: load ch1=250, up step 8 -> ch1=2, o_overflow[1]=1; i_clear_flags -> 0.
REQ-038 MODE 1: load ch2=3, down step 5 -> ch2=0, o_underflow[2]=1; again -> stays 0, flag 1.
REQ-039 Load ch3=100 while all enabled up step 2 (from 10) -> ch3=100, ch0..ch2=12.
REQ-040 i_init and i_load same cycle -> all channels 0; reset asserted mid-count -> all 0, flags 0 next edge.
REQ-041 i_clear_flags same cycle as ch0 wrap 255+1 -> ch0=0, o_overflow[0]=1.

Source files
------------

// File: rtl/multi_counter_pkg.sv
// Shared definitions for the multi_counter slice.
//   MODE_WRAP     : on crossing a limit, keep the result modulo 2^BITS
//   MODE_SATURATE : on crossing a limit, clamp to 0 or 2^BITS-1
// Both modes raise the sticky flag of the channel that crossed.
package multi_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Width of a channel index, at least one bit even for a single channel.
  function automatic int chan_idx_bits(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/multi_counter_channel.sv
// counter_channel: one up/down counter with sticky crossing flags.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   init              : clear the value (flags untouched)
//   load, load_value  : load this channel (flags untouched)
//   enable, up, step  : count by zero-extended step, up=1 adds, up=0 subtracts
//   clear_flags       : clear overflow/underflow unless a crossing happens now
//   value             : registered count
//   overflow/underflow: sticky crossing flags
//   at_max/at_min     : combinational limit indicators
// Priority per cycle: reset > init > load > count > hold.
module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int STEP_BITS = 4,
  parameter int MODE      = MODE_WRAP
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 load,
  input  logic [BITS-1:0]      load_value,
  input  logic                 enable,
  input  logic                 up,
  input  logic [STEP_BITS-1:0] step,
  input  logic                 clear_flags,
  output logic [BITS-1:0]      value,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 at_max,
  output logic                 at_min
);

  localparam logic [BITS-1:0] MAX_VALUE = {BITS{1'b1}};

  logic [BITS:0]   step_ext;
  logic [BITS:0]   result;
  logic            crossed;
  logic            counting;
  logic [BITS-1:0] count_value;
  logic [BITS-1:0] value_next;
  logic            overflow_next;
  logic            underflow_next;

  assign step_ext = (BITS+1)'(step);
  assign counting = enable && !init && !load;

  // At BITS+1 width the top bit marks a crossing in both directions:
  // an up sum above 2^BITS-1, or a down difference that went negative.
  // step <= 2^BITS-1 guarantees neither case can alias back.
  assign result  = up ? ({1'b0, value} + step_ext) : ({1'b0, value} - step_ext);
  assign crossed = counting && result[BITS];

  always_comb begin
    count_value = result[BITS-1:0];
    if (result[BITS] && (MODE == MODE_SATURATE)) begin
      count_value = up ? MAX_VALUE : '0;
    end
  end

  always_comb begin
    value_next = value;
    if (init) begin
      value_next = '0;
    end else if (load) begin
      value_next = load_value;
    end else if (enable) begin
      value_next = count_value;
    end
  end

  // A crossing in the same cycle as clear_flags wins.
  always_comb begin
    overflow_next  = overflow;
    underflow_next = underflow;
    if (clear_flags) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (crossed && up) begin
      overflow_next = 1'b1;
    end
    if (crossed && !up) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      value     <= value_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  assign at_max = (value == MAX_VALUE);
  assign at_min = (value == '0);

endmodule

// File: rtl/multi_counter.sv
// multi_counter: CHANNELS independent up/down counters sharing a step,
// an init, a load bus and a flag clear.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   i_init             : clear all channel values
//   i_enable, i_inc_dec: per-channel enable and direction (1 = up)
//   i_step             : shared step magnitude
//   i_load, i_load_chan, i_load_value : load one channel; an index
//                        outside 0..CHANNELS-1 loads nothing
//   i_clear_flags      : clear all sticky flags
//   o_value            : channel n at [n*BITS +: BITS]
//   o_overflow/o_underflow : sticky crossing flags
//   o_at_max/o_at_min  : per-channel limit indicators
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int CHANNELS  = 4,
  parameter int STEP_BITS = 4,
  parameter int MODE      = MODE_WRAP,
  localparam int LCW      = chan_idx_bits(CHANNELS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_init,
  input  logic [CHANNELS-1:0]      i_enable,
  input  logic [CHANNELS-1:0]      i_inc_dec,
  input  logic [STEP_BITS-1:0]     i_step,
  input  logic                     i_load,
  input  logic [LCW-1:0]           i_load_chan,
  input  logic [BITS-1:0]          i_load_value,
  input  logic                     i_clear_flags,
  output logic [CHANNELS*BITS-1:0] o_value,
  output logic [CHANNELS-1:0]      o_overflow,
  output logic [CHANNELS-1:0]      o_underflow,
  output logic [CHANNELS-1:0]      o_at_max,
  output logic [CHANNELS-1:0]      o_at_min
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    logic load_hit;
    assign load_hit = i_load && (i_load_chan == LCW'(n));

    counter_channel #(
      .BITS      (BITS),
      .STEP_BITS (STEP_BITS),
      .MODE      (MODE)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .init        (i_init),
      .load        (load_hit),
      .load_value  (i_load_value),
      .enable      (i_enable[n]),
      .up          (i_inc_dec[n]),
      .step        (i_step),
      .clear_flags (i_clear_flags),
      .value       (o_value[n*BITS +: BITS]),
      .overflow    (o_overflow[n]),
      .underflow   (o_underflow[n]),
      .at_max      (o_at_max[n]),
      .at_min      (o_at_min[n])
    );
  end

endmodule
